// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Multi-cycle subtractor computing diff = a - b - bin over a
//            WIDTH-bit word, DIGIT bits per clock, LSB digit first. The
//            borrow ripples between digits through a register, so one
//            operation takes NDIG = WIDTH/DIGIT cycles in RUN.
// Build    : define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
// Ports    : clk        clock, rising edge
//            rst        synchronous active-high reset
//            in_valid   operands a/b/bin are valid
//            in_ready   block can accept operands (IDLE only)
//            a, b       minuend / subtrahend, WIDTH bits
//            bin        borrow-in
//            out_valid  diff/bout(/ovf) valid (DONE only)
//            out_ready  consumer accepts the result
//            diff       a - b - bin mod 2^WIDTH
//            bout       borrow-out, 1 when a < b + bin (unsigned)
//            ovf        signed overflow (SERIAL_SUB_OVF_EN only)
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // WIDTH >= 1, 1 <= DIGIT <= WIDTH and WIDTH % DIGIT == 0 are assumed.
  localparam int NDIG = WIDTH / DIGIT;
  localparam int CNTW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNTW-1:0] c_last_digit = CNTW'(NDIG - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [WIDTH-1:0]  r_a;
  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_diff;
  logic              r_borrow;
  logic [CNTW-1:0]   r_cnt;

  logic              w_accept;
  logic              w_step;
  logic              w_last;

  logic [DIGIT-1:0]  w_a_dig;
  logic [DIGIT-1:0]  w_b_dig;
  logic [DIGIT:0]    w_sub;
  logic [WIDTH-1:0]  w_a_shift;
  logic [WIDTH-1:0]  w_b_shift;
  logic [WIDTH-1:0]  w_diff_shift;

  // --------------------------------------------------------------------------
  // Control FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (r_cnt == c_last_digit) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Digit datapath
  // The operand registers shift right by one digit per step, so the current
  // digit is always in the low DIGIT bits; result digits enter from the top
  // and land in their final position after NDIG steps.
  // --------------------------------------------------------------------------
  assign w_a_dig = r_a[DIGIT-1:0];
  assign w_b_dig = r_b[DIGIT-1:0];

  // DIGIT+1-bit difference: the MSB is 1 exactly when the digit underflowed,
  // which is the borrow into the next digit.
  assign w_sub = {1'b0, w_a_dig} - {1'b0, w_b_dig} - {{DIGIT{1'b0}}, r_borrow};

  generate
    if (NDIG > 1) begin : g_multi_digit
      assign w_a_shift    = {{DIGIT{1'b0}}, r_a[WIDTH-1:DIGIT]};
      assign w_b_shift    = {{DIGIT{1'b0}}, r_b[WIDTH-1:DIGIT]};
      assign w_diff_shift = {w_sub[DIGIT-1:0], r_diff[WIDTH-1:DIGIT]};
    end else begin : g_single_digit
      assign w_a_shift    = r_a;
      assign w_b_shift    = r_b;
      assign w_diff_shift = w_sub[DIGIT-1:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a      <= a;
      r_b      <= b;
      r_borrow <= bin;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_a      <= w_a_shift;
      r_b      <= w_b_shift;
      r_diff   <= w_diff_shift;
      r_borrow <= w_sub[DIGIT];
      r_cnt    <= w_last ? '0 : r_cnt + CNTW'(1);
    end
  end

  assign diff = r_diff;
  // Only the final borrow is meaningful, and only while out_valid is high.
  assign bout = r_borrow;

`ifdef SERIAL_SUB_OVF_EN
  // --------------------------------------------------------------------------
  // Signed overflow. The operand registers are shifted away during RUN, so
  // their sign bits are kept separately. On the last digit w_sub[DIGIT-1] is
  // the result sign bit.
  // --------------------------------------------------------------------------
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= a[WIDTH-1];
      r_b_msb <= b[WIDTH-1];
    end else if (w_last) begin
      r_ovf   <= (r_a_msb != r_b_msb) && (w_sub[DIGIT-1] != r_a_msb);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor
// Purpose  : Self-checking bench for serial_subtractor. A 16/4 instance is
//            driven with directed and random operations through a scoreboard
//            queue; three WIDTH=8 instances (DIGIT=1,2,8) are swept against a
//            reference model with latency checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

  localparam int W    = 16;
  localparam int D    = 4;
  localparam int NDIG = W / D;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference models: whole-word subtraction, independent of digit slicing.
  // ---------------------------------------------------------------------------
  function automatic logic [17:0] ref16(input logic [15:0] x, input logic [15:0] y, input logic bi);
    logic [16:0] full;
    logic        ov;
    full = {1'b0, x} - {1'b0, y} - {16'd0, bi};
    ov   = (x[15] != y[15]) && (full[15] != x[15]);
    return {ov, full[16], full[15:0]};
  endfunction

  function automatic logic [9:0] ref8(input logic [7:0] x, input logic [7:0] y, input logic bi);
    logic [8:0] full;
    logic       ov;
    full = {1'b0, x} - {1'b0, y} - {8'd0, bi};
    ov   = (x[7] != y[7]) && (full[7] != x[7]);
    return {ov, full[8], full[7:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Main 16/4 instance
  // ---------------------------------------------------------------------------
  logic          rst = 1'b1;
  logic          m_in_valid = 1'b0;
  logic          m_in_ready;
  logic [W-1:0]  m_a = '0;
  logic [W-1:0]  m_b = '0;
  logic          m_bin = 1'b0;
  logic          m_out_valid;
  logic          m_out_ready = 1'b1;
  logic [W-1:0]  m_diff;
  logic          m_bout;
  logic          m_ovf;

  serial_subtractor #(.WIDTH(W), .DIGIT(D)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .a         (m_a),
    .b         (m_b),
    .bin       (m_bin),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .diff      (m_diff),
    .bout      (m_bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (m_ovf)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign m_ovf = 1'b0;
`endif

  typedef struct {
    logic [15:0] d;
    logic        bo;
    logic        ov;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t e_pop;
  logic prev_ov = 1'b0;

  // Result monitor: latency on the rising out_valid, values on the handshake.
  always @(negedge clk) begin
    if (rst) begin
      prev_ov = 1'b0;
    end else begin
      if (m_out_valid && !prev_ov) begin
        if (sb.size() == 0) check_eq("unexpected_out_valid", 32'd1, 32'd0);
        else                check_eq("latency", 32'(cyc - sb[0].acc), 32'(NDIG));
      end
      if (m_out_valid && m_out_ready && sb.size() > 0) begin
        e_pop = sb.pop_front();
        check_eq("diff", 32'(m_diff), 32'(e_pop.d));
        check_eq("bout", 32'(m_bout), 32'(e_pop.bo));
`ifdef SERIAL_SUB_OVF_EN
        check_eq("ovf", 32'(m_ovf), 32'(e_pop.ov));
`endif
      end
      prev_ov = m_out_valid;
    end
  end

  // All drive tasks assume they are entered 1 time unit after a rising edge.
  task automatic drive_op(input logic [15:0] ta, input logic [15:0] tb_, input logic tbin);
    int          n;
    exp_t        e;
    logic [17:0] r;
    n = 0;
    while (!m_in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!m_in_ready) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
    end else begin
      m_in_valid = 1'b1;
      m_a        = ta;
      m_b        = tb_;
      m_bin      = tbin;
      @(posedge clk); #1;
      m_in_valid = 1'b0;
      r     = ref16(ta, tb_, tbin);
      e.d   = r[15:0];
      e.bo  = r[16];
      e.ov  = r[17];
      e.acc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(m_in_ready && sb.size() == 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check_eq("result_timeout", 32'd0, 32'd1);
  endtask

  // ---------------------------------------------------------------------------
  // WIDTH=8 sweep instances (DIGIT = 8, 2, 1), shared inputs
  // ---------------------------------------------------------------------------
  logic       s_in_valid = 1'b0;
  logic [7:0] s_a = '0;
  logic [7:0] s_b = '0;
  logic       s_bin = 1'b0;
  logic [2:0] s_in_ready;
  logic [2:0] s_out_valid;
  logic [2:0] s_bout;
  logic [2:0] s_ovf;
  logic [7:0] s_diff [3];
  int         s_ndig [3] = '{1, 4, 8};

  serial_subtractor #(.WIDTH(8), .DIGIT(8)) u_sw8 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[0]),
    .a(s_a), .b(s_b), .bin(s_bin), .out_valid(s_out_valid[0]), .out_ready(1'b1),
    .diff(s_diff[0]), .bout(s_bout[0])
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(s_ovf[0])
`endif
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(2)) u_sw2 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[1]),
    .a(s_a), .b(s_b), .bin(s_bin), .out_valid(s_out_valid[1]), .out_ready(1'b1),
    .diff(s_diff[1]), .bout(s_bout[1])
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(s_ovf[1])
`endif
  );

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_sw1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready[2]),
    .a(s_a), .b(s_b), .bin(s_bin), .out_valid(s_out_valid[2]), .out_ready(1'b1),
    .diff(s_diff[2]), .bout(s_bout[2])
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(s_ovf[2])
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign s_ovf = 3'b000;
`endif

  task automatic sweep_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin);
    logic [9:0] r;
    logic [2:0] seen;
    int         acc;
    int         n;
    n = 0;
    while (s_in_ready != 3'b111 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (s_in_ready != 3'b111) begin
      check_eq("sweep_accept_timeout", 32'(s_in_ready), 32'd7);
    end else begin
      s_in_valid = 1'b1;
      s_a        = ta;
      s_b        = tb_;
      s_bin      = tbin;
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      acc  = cyc;
      r    = ref8(ta, tb_, tbin);
      seen = 3'b000;
      n    = 0;
      while (seen != 3'b111 && n < 20) begin
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          if (s_out_valid[i] && !seen[i]) begin
            seen[i] = 1'b1;
            check_eq($sformatf("sweep%0d_latency", i), 32'(cyc - acc), 32'(s_ndig[i]));
            check_eq($sformatf("sweep%0d_diff", i), 32'(s_diff[i]), 32'(r[7:0]));
            check_eq($sformatf("sweep%0d_bout", i), 32'(s_bout[i]), 32'(r[8]));
`ifdef SERIAL_SUB_OVF_EN
            check_eq($sformatf("sweep%0d_ovf", i), 32'(s_ovf[i]), 32'(r[9]));
`endif
          end
        end
        n++;
      end
      if (seen != 3'b111) check_eq("sweep_result_timeout", 32'(seen), 32'd7);
      @(posedge clk); #1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(m_in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(m_out_valid), 32'd0);
    check_eq("rst_diff", 32'(m_diff), 32'd0);
    check_eq("rst_bout", 32'(m_bout), 32'd0);
    check_eq("rst_ovf", 32'(m_ovf), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic and underflow
    drive_op(16'h1234, 16'h0234, 1'b0);
    wait_idle();
    drive_op(16'h0000, 16'h0001, 1'b0);
    wait_idle();
    drive_op(16'h0005, 16'h0005, 1'b1);
    wait_idle();

    // Backpressure: result held for 5 cycles with out_ready low
    m_out_ready = 1'b0;
    drive_op(16'hABCD, 16'h1234, 1'b1);
    n = 0;
    while (!m_out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("bp_out_valid_rise", 32'(m_out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check_eq("bp_hold_valid", 32'(m_out_valid), 32'd1);
      check_eq("bp_hold_diff", 32'(m_diff), 32'h9998);
      check_eq("bp_hold_bout", 32'(m_bout), 32'd0);
      check_eq("bp_hold_in_ready", 32'(m_in_ready), 32'd0);
    end
    m_out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_in_ready_after", 32'(m_in_ready), 32'd1);
    check_eq("bp_out_valid_after", 32'(m_out_valid), 32'd0);
    wait_idle();

    // Reset mid-RUN after two digits
    drive_op(16'hF0F0, 16'h0F0F, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    check_eq("run_in_ready", 32'(m_in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    check_eq("midrst_in_ready", 32'(m_in_ready), 32'd1);
    check_eq("midrst_out_valid", 32'(m_out_valid), 32'd0);
    check_eq("midrst_diff", 32'(m_diff), 32'd0);
    for (int i = 0; i < NDIG + 2; i++) begin
      @(posedge clk); #1;
      check_eq("midrst_discarded", 32'(m_out_valid), 32'd0);
    end
    drive_op(16'h00FF, 16'h000F, 1'b0);
    wait_idle();

    // in_valid together with rst is ignored
    rst        = 1'b1;
    m_in_valid = 1'b1;
    m_a        = 16'h1111;
    m_b        = 16'h2222;
    @(posedge clk); #1;
    rst        = 1'b0;
    m_in_valid = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_valid_ignored", 32'(m_in_ready), 32'd1);

    // Signed-overflow corner operands
    drive_op(16'h8000, 16'h0001, 1'b0);
    wait_idle();
    drive_op(16'h7FFF, 16'hFFFF, 1'b0);
    wait_idle();
    drive_op(16'hFFFF, 16'hFFFF, 1'b1);
    wait_idle();

    // Random operations with occasional consumer stalls
    for (int i = 0; i < 40; i++) begin
      m_out_ready = ($urandom_range(0, 3) != 0);
      drive_op(16'($urandom), 16'($urandom), 1'($urandom));
      n = 0;
      while (!m_out_valid && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      m_out_ready = 1'b1;
      wait_idle();
    end

    // WIDTH=8 parameter sweep
    sweep_op(8'h00, 8'h00, 1'b1);
    sweep_op(8'hFF, 8'hFF, 1'b0);
    sweep_op(8'h80, 8'h01, 1'b0);
    for (int i = 0; i < 256; i++) begin
      sweep_op(8'($urandom), 8'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/serial_subtractor.md
# serial_subtractor

Parametrised multi-cycle subtractor computing `diff = a - b - bin` over a WIDTH-bit word, DIGIT bits per clock, with the borrow rippled between digits through a register. It extends the single-bit half subtractor to full-width words with a borrow-in and a valid/ready handshake on both sides. It sits in the datapath library as an area-cheap arithmetic unit for blocks that can tolerate multi-cycle latency.

## Interface
- `WIDTH`, 16, operand/result width in bits; must be ≥ 1.
- `DIGIT`, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH, WIDTH % DIGIT == 0.
- Derived: `NDIG = WIDTH/DIGIT`, the cycles per operation.

- `clk`  in  1  clock; all state is updated on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`  in  1  operands are valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  WIDTH  minuend.
- `b`  in  WIDTH  subtrahend.
- `bin`  in  1  borrow-in.
- `out_valid`  out  1  result is valid.
- `out_ready`  in  1  consumer accepts the result.
- `diff`  out  WIDTH  difference, `a - b - bin` mod 2^WIDTH.
- `bout`  out  1  borrow-out; 1 when `a < b + bin` (unsigned).
- `ovf`  out  1  signed overflow; present only with `SERIAL_SUB_OVF_EN`.

## Operation
- FSM states:
  - IDLE: `in_ready=1`. On `in_valid`, latch `a`, `b` and `bin` into internal registers, clear the digit counter and go to RUN.
  - RUN: each cycle, take digit `k` (bits `[k*DIGIT +: DIGIT]`, LSB digit first) and compute `{borrow', d} = a_k - b_k - borrow`. Write `d` into result bits of digit `k`, register `borrow'`, and increment `k`. After digit NDIG-1, go to DONE.
  - DONE: `out_valid=1`. `diff` holds the full result and `bout` holds the final borrow. On `out_ready`, go to IDLE.
- The borrow register is initialised from `bin` at accept time.
- Each digit difference is computed at DIGIT+1 bits. The MSB of that result is the borrow for the next digit.
- `in_ready` is 0 in RUN and DONE. Operands offered there are not accepted and must be held by the producer.
- `diff`, `bout` and `ovf` are stable for the whole time `out_valid=1`. Their values outside DONE are don't-care except after reset.
- Reset, from any state including mid-RUN or DONE: go to IDLE and discard the operation in flight.
  - Reset values: `in_ready=1`, `out_valid=0`, `diff=0`, `bout=0`, `ovf=0`.
  - All internal registers and the counter reset to 0.
- `in_valid` asserted together with `rst` is ignored.
- Wrap-around is mod 2^WIDTH; no saturation.

## Timing
- Accept edge: `in_valid && in_ready` sampled at rising edge T.
- `out_valid` rises after edge T+NDIG, so it is visible in the cycle following that edge. Latency from accept to result is NDIG cycles.
- Handshake completes at the edge where `out_valid && out_ready`. `in_ready` is 1 in the next cycle.
- Throughput: one operation per NDIG+2 cycles minimum. There is no overlap between an operation and the next accept.
- `out_ready` is ignored outside DONE.
- DIGIT == WIDTH gives NDIG=1: the result is valid one cycle after accept.

## Configuration
- `SERIAL_SUB_OVF_EN` defined:
  - Port `ovf` exists. It is registered in DONE as `(a[MSB] != b[MSB]) && (diff[MSB] != a[MSB])`, using the latched operands.
  - `bin` participates in the result, so `ovf` reflects the full `a - b - bin`.
- Not defined: port `ovf` and its logic are absent; all other behaviour is identical.

## Test plan
All scenarios use WIDTH=16, DIGIT=4 unless stated.
1. Basic: a=0x1234, b=0x0234, bin=0 → after 4 cycles `out_valid=1`, diff=0x1000, bout=0.
2. Underflow: a=0x0000, b=0x0001, bin=0 → diff=0xFFFF, bout=1. Then a=0x0005, b=0x0005, bin=1 → diff=0xFFFF, bout=1.
3. Backpressure: hold `out_ready=0` for 5 cycles in DONE → diff, bout and `out_valid` remain stable and `in_ready=0`. Raise `out_ready` → `in_ready=1` the next cycle.
4. Reset mid-RUN: assert `rst` for 1 cycle after 2 digits → `in_ready=1`, `out_valid=0`, diff=0. A new operation a=0x00FF, b=0x000F → diff=0x00F0.
5. Overflow (macro defined): a=0x8000, b=0x0001 → diff=0x7FFF, ovf=1, bout=0. a=0x7FFF, b=0xFFFF → diff=0x8000, ovf=1, bout=1.
6. Parameter sweep: WIDTH=8 with DIGIT=1, 2, 8, checked against a reference model over 256 random operand pairs with random bin → all results match and the latency equals NDIG.
